// File: rtl/anf_fl_tex_block_fetch_if.sv
// Handshake bundle between texture requester, memory read port and ETC2 block decoder.
// Latency: none, wires only.
// Backpressure: valid/ready on request, memory request and block output; memory response has no ready.
interface anf_fl_tex_block_fetch_if #(
   parameter int ADDR_W = 32
) ();
   // texel request
   logic              reqValid;
   logic              reqReady;
   logic [11:0]       reqU;
   logic [11:0]       reqV;
   logic [ADDR_W-1:0] reqBase;
   logic [9:0]        reqPitch;
   logic [4:0]        reqFormat;
   // memory read port
   logic              memReqValid;
   logic              memReqReady;
   logic [ADDR_W-1:0] memAddr;
   logic              memRespValid;
   logic [31:0]       memRespData;
   // cache control
   logic              flush;
   // decoder side
   logic              outValid;
   logic              outReady;
   logic [127:0]      outData;
   logic [4:0]        outFormat;
   logic [1:0]        outXTexel;
   logic [1:0]        outYTexel;

   // environment view: requester, memory model and decoder
   modport master (
      output reqValid, reqU, reqV, reqBase, reqPitch, reqFormat,
      output memReqReady, memRespValid, memRespData,
      output flush, outReady,
      input  reqReady, memReqValid, memAddr,
      input  outValid, outData, outFormat, outXTexel, outYTexel
   );

   // fetch block view
   modport slave (
      input  reqValid, reqU, reqV, reqBase, reqPitch, reqFormat,
      input  memReqReady, memRespValid, memRespData,
      input  flush, outReady,
      output reqReady, memReqValid, memAddr,
      output outValid, outData, outFormat, outXTexel, outYTexel
   );
endinterface

// File: rtl/anf_fl_tex_block_fetch.sv
// Texture block fetch: texel coord -> block address, 32-bit beat fetch, single-entry block cache.
// Latency: hit -> outValid the cycle after accept; miss -> 2*beats+1 cycles with a zero-wait memory.
// Backpressure: reqReady only in IDLE; memory request and block output hold stable until their ready.
module anf_fl_tex_block_fetch #(
   parameter int ADDR_W = 32
) (
   input  logic clk,
   input  logic rst_n,
   anf_fl_tex_block_fetch_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} fetchState_e;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic              is16;
      logic [127:0]      data;
   } cacheEntry_t;

   fetchState_e       state;
   fetchState_e       stateNxt;
   cacheEntry_t       tag;

   logic [ADDR_W-1:0] addrQ;
   logic [4:0]        fmtQ;
   logic [1:0]        xQ;
   logic [1:0]        yQ;
   logic [1:0]        beat;
   logic [127:0]      stage;
   logic              flushSeen;

   logic [20:0]       blkIdx;
   logic [ADDR_W-1:0] blkOff;
   logic [ADDR_W-1:0] reqAddr;
   logic              hit;
   logic              accept;
   logic              respTake;
   logic              lastBeat;
   logic [127:0]      stageNew;
   logic              unusedBaseBits;

   // low base bits are dropped by the 16-byte block alignment
   assign unusedBaseBits = ^bus.reqBase[3:0];

   // block address of the incoming request and cache lookup; a flush in the accept cycle forces a miss
   always_comb begin
      blkIdx  = ({11'd0, bus.reqV[11:2]} * {11'd0, bus.reqPitch}) + {11'd0, bus.reqU[11:2]};
      blkOff  = ADDR_W'(blkIdx) << (bus.reqFormat[4] ? 4 : 3);
      reqAddr = {bus.reqBase[ADDR_W-1:4], 4'b0000} + blkOff;
      hit     = tag.valid && !bus.flush && (tag.addr == reqAddr) && (tag.is16 == bus.reqFormat[4]);
   end

   assign accept   = (state == IDLE) && bus.reqValid;
   assign respTake = (state == RESP) && bus.memRespValid;
   assign lastBeat = (beat == (fmtQ[4] ? 2'd3 : 2'd1));

   // staging data with the arriving beat merged in, used for both the staging and the cache fill
   always_comb begin
      stageNew = stage;
      stageNew[{beat, 5'b00000} +: 32] = bus.memRespData;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNxt;
   end

   // next-state and state-decoded handshake outputs
   always_comb begin
      stateNxt        = state;
      bus.reqReady    = 1'b0;
      bus.memReqValid = 1'b0;
      bus.memAddr     = '0;
      bus.outValid    = 1'b0;
      case (state)
         IDLE: begin
            bus.reqReady = 1'b1;
            if (bus.reqValid) stateNxt = hit ? OUT : REQ;
         end
         REQ: begin
            bus.memReqValid = 1'b1;
            bus.memAddr     = addrQ + ADDR_W'({beat, 2'b00});
            if (bus.memReqReady) stateNxt = RESP;
         end
         RESP: begin
            if (bus.memRespValid) stateNxt = lastBeat ? OUT : REQ;
         end
         OUT: begin
            bus.outValid = 1'b1;
            if (bus.outReady) stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   // request latch, beat counter and block staging register (which is also the output data)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addrQ <= '0;
         fmtQ  <= '0;
         xQ    <= '0;
         yQ    <= '0;
         beat  <= '0;
         stage <= '0;
      end else if (accept) begin
         addrQ <= reqAddr;
         fmtQ  <= bus.reqFormat;
         xQ    <= bus.reqU[1:0];
         yQ    <= bus.reqV[1:0];
         beat  <= '0;
         stage <= hit ? tag.data : '0;
      end else if (respTake) begin
         stage <= stageNew;
         if (!lastBeat) beat <= beat + 2'd1;
      end
   end

   // cache entry: flush always wins over a fill landing on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag <= '0;
      end else if (bus.flush) begin
         tag.valid <= 1'b0;
      end else if (respTake && lastBeat && !flushSeen) begin
         tag.valid <= 1'b1;
         tag.addr  <= addrQ;
         tag.is16  <= fmtQ[4];
         tag.data  <= stageNew;
      end
   end

   // sticky record of a flush during a fetch, so stale data never gets tagged valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 flushSeen <= 1'b0;
      else if ((state == OUT) && bus.outReady)    flushSeen <= 1'b0;
      else if (bus.flush && ((state == REQ) || (state == RESP))) flushSeen <= 1'b1;
   end

   assign bus.outData   = stage;
   assign bus.outFormat = fmtQ;
   assign bus.outXTexel = xQ;
   assign bus.outYTexel = yQ;

endmodule

// File: tb/tb_anf_fl_tex_block_fetch.sv
// Bench for the texture block fetch stage: directed plan followed by randomized requests.
// Latency: expected from a cache/memory model, checked per transaction.
// Backpressure: stalls memory acceptance and decoder ready to exercise hold behaviour.
module tb_anf_fl_tex_block_fetch;

   logic clk;
   logic rst_n;
   int   assertCnt = 0;
   int   failCnt   = 0;

   // reference state: one cached block identity, plus memory contents
   bit          mValid;
   logic [31:0] mAddr;
   bit          mIs16;
   logic [31:0] memInit [logic [31:0]];

   anf_fl_tex_block_fetch_if #(.ADDR_W(32)) bus ();

   anf_fl_tex_block_fetch #(.ADDR_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, failures so far %0d", failCnt);
      $fatal(1, "watchdog");
   end

   task automatic checkVal(input string tag, input logic [127:0] act, input logic [127:0] exp);
      assertCnt++;
      if (act !== exp) begin
         failCnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (memInit.exists(a)) return memInit[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // byte address of the compressed block holding texel (u,v)
   function automatic logic [31:0] blockAddr(input int u, input int v, input logic [31:0] base,
                                             input int pitch, input bit is16);
      longint b;
      longint idx;
      b   = base;
      b   = b - (b % 16);
      idx = longint'(v / 4) * pitch + (u / 4);
      return 32'(b + idx * (is16 ? 16 : 8));
   endfunction

   task automatic checkResetOutputs(input string pfx);
      checkVal({pfx, "_reqReady"},    bus.reqReady,    1);
      checkVal({pfx, "_memReqValid"}, bus.memReqValid, 0);
      checkVal({pfx, "_memAddr"},     bus.memAddr,     0);
      checkVal({pfx, "_outValid"},    bus.outValid,    0);
      checkVal({pfx, "_outData"},     bus.outData,     0);
      checkVal({pfx, "_outFormat"},   bus.outFormat,   0);
      checkVal({pfx, "_outXTexel"},   bus.outXTexel,   0);
      checkVal({pfx, "_outYTexel"},   bus.outYTexel,   0);
   endtask

   // one request end to end; called and returning at a falling edge
   task automatic runReq(input logic [11:0] u, input logic [11:0] v, input logic [31:0] base,
                         input logic [9:0] pitch, input logic [4:0] fmt,
                         input int memStall, input int outStall, input int flushAtBeat,
                         input bit flushAtAccept, input int resetAfterBeat);
      logic [31:0]  addr;
      logic [127:0] expData;
      logic [31:0]  respDat;
      int           beats;
      bit           hit;
      int           cyc;
      int           issued;
      int           resp;
      int           stallLeft;
      int           outLeft;
      bit           respNext;
      bit           done;
      bit           seenOut;
      bit           flushDriven;
      bit           wasReset;

      addr  = blockAddr(int'(u), int'(v), base, int'(pitch), fmt[4]);
      beats = fmt[4] ? 4 : 2;
      hit   = mValid && !flushAtAccept && (mAddr == addr) && (mIs16 == fmt[4]);
      expData = '0;
      for (int k = 0; k < beats; k++) expData[32*k +: 32] = memRead(addr + 32'(4*k));

      checkVal("reqReady_idle", bus.reqReady, 1);
      bus.reqValid  = 1'b1;
      bus.reqU      = u;
      bus.reqV      = v;
      bus.reqBase   = base;
      bus.reqPitch  = pitch;
      bus.reqFormat = fmt;
      bus.flush     = flushAtAccept;
      @(negedge clk);
      // scramble request fields so the outputs must come from latched copies
      bus.reqValid  = 1'b0;
      bus.flush     = 1'b0;
      bus.reqU      = 12'($urandom);
      bus.reqV      = 12'($urandom);
      bus.reqFormat = 5'($urandom);

      cyc = 1; issued = 0; resp = 0; stallLeft = memStall; outLeft = outStall;
      respNext = 0; done = 0; seenOut = 0; flushDriven = 0; wasReset = 0;
      while (!done && cyc < 400) begin
         bus.memRespValid = 1'b0;
         bus.memReqReady  = 1'b0;
         bus.outReady     = 1'b0;
         bus.flush        = 1'b0;
         if (resetAfterBeat >= 0 && resp == resetAfterBeat + 1 && !respNext) begin
            rst_n = 1'b0;
            #1;
            checkResetOutputs("midReset");
            @(negedge clk);
            rst_n    = 1'b1;
            mValid   = 0;
            wasReset = 1;
            done     = 1;
         end else begin
            if (!bus.outValid) checkVal("reqReady_busy", bus.reqReady, 0);
            if (respNext) begin
               bus.memRespValid = 1'b1;
               bus.memRespData  = respDat;
               respNext = 0;
               if (flushAtBeat == resp) begin
                  bus.flush   = 1'b1;
                  flushDriven = 1;
               end
               resp++;
            end
            if (bus.memReqValid) begin
               checkVal("memAddr", bus.memAddr, addr + 32'(4*issued));
               if (stallLeft > 0) begin
                  stallLeft--;
               end else begin
                  bus.memReqReady = 1'b1;
                  respDat  = memRead(addr + 32'(4*issued));
                  respNext = 1;
                  issued++;
               end
            end
            if (bus.outValid) begin
               if (!seenOut) begin
                  seenOut = 1;
                  if (memStall == 0) checkVal("outLatency", cyc, hit ? 1 : 2*beats + 1);
               end
               checkVal("outData",   bus.outData,   expData);
               checkVal("outFormat", bus.outFormat, fmt);
               checkVal("outXTexel", bus.outXTexel, u[1:0]);
               checkVal("outYTexel", bus.outYTexel, v[1:0]);
               if (outLeft > 0) outLeft--;
               else begin
                  bus.outReady = 1'b1;
                  done = 1;
               end
            end
            @(negedge clk);
            cyc++;
         end
      end
      bus.memRespValid = 1'b0;
      bus.memReqReady  = 1'b0;
      bus.outReady     = 1'b0;
      bus.flush        = 1'b0;
      if (!done) checkVal("timeout", 0, 1);
      if (!wasReset) begin
         checkVal("memBeats", issued, hit ? 0 : beats);
         if (flushDriven) mValid = 0;
         else if (!hit) begin
            mValid = 1;
            mAddr  = addr;
            mIs16  = fmt[4];
         end
      end
   endtask

   initial begin
      logic [11:0] ru;
      logic [11:0] rv;
      logic [31:0] rbase;
      logic [9:0]  rpitch;
      logic [4:0]  rfmt;
      logic [4:0]  fmtTab [4];
      int          fb;

      fmtTab[0] = 5'h00; fmtTab[1] = 5'h10; fmtTab[2] = 5'h13; fmtTab[3] = 5'h0A;
      mValid = 0; mAddr = '0; mIs16 = 0;
      memInit[32'h1090] = 32'h1111_1111;
      memInit[32'h1094] = 32'h2222_2222;
      memInit[32'h1098] = 32'h3333_3333;
      memInit[32'h109C] = 32'h4444_4444;

      rst_n = 1'b0;
      bus.reqValid = 1'b0; bus.reqU = '0; bus.reqV = '0; bus.reqBase = '0;
      bus.reqPitch = '0; bus.reqFormat = '0; bus.memReqReady = 1'b0;
      bus.memRespValid = 1'b0; bus.memRespData = '0; bus.flush = 1'b0; bus.outReady = 1'b0;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // miss on a 16-byte block, then a hit on the same block at other texels
      runReq(12'd5, 12'd9, 32'h1000, 10'd4, 5'h10, 0, 0, -1, 0, -1);
      runReq(12'd6, 12'd10, 32'h1000, 10'd4, 5'h10, 0, 0, -1, 0, -1);
      // 8-byte block, upper half of outData stays zero
      runReq(12'd4, 12'd0, 32'h2000, 10'd4, 5'h00, 0, 0, -1, 0, -1);
      // memory and decoder backpressure
      runReq(12'd0, 12'd0, 32'h3000, 10'd4, 5'h10, 5, 3, -1, 0, -1);
      // flush during a fetch: delivered but not cached, so the repeat misses, then hits
      runReq(12'd5, 12'd9, 32'h1000, 10'd4, 5'h10, 0, 0, 1, 0, -1);
      runReq(12'd5, 12'd9, 32'h1000, 10'd4, 5'h10, 0, 0, -1, 0, -1);
      runReq(12'd7, 12'd11, 32'h1000, 10'd4, 5'h10, 0, 0, -1, 0, -1);
      // flush coincident with accept turns a would-be hit into a miss
      runReq(12'd5, 12'd9, 32'h1000, 10'd4, 5'h10, 0, 0, -1, 1, -1);
      // reset in the middle of a fetch, stray response afterwards, then a clean refetch
      runReq(12'd8, 12'd4, 32'h4000, 10'd4, 5'h10, 0, 0, -1, 0, 1);
      bus.memRespValid = 1'b1;
      bus.memRespData  = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.memRespValid = 1'b0;
      checkVal("stray_outData", bus.outData, 0);
      checkVal("stray_reqReady", bus.reqReady, 1);
      runReq(12'd8, 12'd4, 32'h4000, 10'd4, 5'h10, 0, 0, -1, 0, -1);

      // randomized traffic over a small texel window so hits are common
      for (int i = 0; i < 60; i++) begin
         ru     = 12'($urandom_range(0, 15));
         rv     = 12'($urandom_range(0, 15));
         rbase  = ($urandom_range(0, 1) == 0) ? 32'h5000 : 32'h5003;
         rpitch = 10'($urandom_range(1, 4));
         rfmt   = fmtTab[$urandom_range(0, 3)];
         fb     = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
         runReq(ru, rv, rbase, rpitch, rfmt, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                fb, ($urandom_range(0, 7) == 0), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule

// File: doc/anf_fl_tex_block_fetch.md
# anf_fl_tex_block_fetch

Texture block fetch stage that sits directly upstream of the ETC2 block decoder. It converts a texel coordinate request into a compressed-block address and fetches the 64- or 128-bit block over a 32-bit memory read port, one beat at a time. A single-entry block cache lets repeated hits skip memory. It then presents the block plus in-block texel coordinates to the decoder with a valid/ready handshake.

## Interface
- ADDR_W, 32, memory byte-address width.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- reqValid  in  1  request valid.
- reqReady  out  1  request accepted when reqValid&&reqReady.
- reqU  in  12  texel x.
- reqV  in  12  texel y.
- reqBase  in  ADDR_W  texture base byte address; bits [3:0] ignored.
- reqPitch  in  10  texture width in blocks.
- reqFormat  in  5  format code; bit 4 = 1 means 16-byte block, 0 means 8-byte block.
- memReqValid  out  1  memory read request.
- memReqReady  in  1  memory accepts request.
- memAddr  out  ADDR_W  word address (byte address, bits [1:0] = 0).
- memRespValid  in  1  read data valid.
- memRespData  in  32  read data.
- flush  in  1  invalidate cache entry.
- outValid  out  1  block output valid.
- outReady  in  1  decoder consumes output.
- outData  out  128  block data; bits [127:64] are zero for 8-byte formats.
- outFormat  out  5  registered reqFormat.
- outXTexel  out  2  reqU[1:0].
- outYTexel  out  2  reqV[1:0].

## Operation
- Block address: blkIdx = (reqV[11:2]*reqPitch) + reqU[11:2], 21 bits unsigned. addr = {reqBase[ADDR_W-1:4],4'b0} + (blkIdx << (reqFormat[4] ? 4 : 3)), modulo 2^ADDR_W.
- Beats: 4 for 16-byte formats, 2 for 8-byte formats. Beat k reads addr+4k and lands in outData[32k+31:32k] (first byte in bits [7:0]).
- Cache: one entry holding {tagValid, tagAddr, tagFormat, data}. A hit requires tagValid, tagAddr==addr and tagFormat[4]==reqFormat[4].
- State machine: IDLE, REQ, RESP, OUT.
  - IDLE: reqReady=1. On accept, latch addr, format and texel bits. A hit goes to OUT with the cached data. A miss clears beat=0, clears the data staging register, and goes to REQ.
  - REQ: memReqValid=1, memAddr=addr+4*beat. On memReqReady, go to RESP.
  - RESP: on memRespValid, store the beat. If it is the last beat, write the tag/data (unless flush was seen during the fetch) and go to OUT. Otherwise beat++ and go to REQ.
  - OUT: outValid=1, outputs stable. On outReady, go to IDLE.
- One outstanding memory request at a time. memRespValid outside RESP is ignored.
- flush: clears tagValid the same edge it is sampled. If flush is sampled while in REQ or RESP, a sticky bit suppresses the tag write at fetch end. The fetched data is still delivered. The sticky bit clears on entering IDLE.
- A flush in IDLE coincident with an accept makes that request a miss.

## Timing
- Reset values:
  - state=IDLE, so reqReady=1.
  - memReqValid=0, memAddr=0.
  - outValid=0, outData=0, outFormat=0, outXTexel=0, outYTexel=0.
  - tagValid=0, beat=0.
- Hit latency: outValid asserts in the cycle after acceptance.
- Miss latency: memReqValid asserts in the cycle after acceptance. With a memory that accepts immediately and responds one cycle later, outValid asserts 2*beats+1 cycles after acceptance (9 for 16-byte, 5 for 8-byte).
- memReqValid and memAddr hold until memReqReady. outValid and outputs hold until outReady. Neither drops while waiting.
- Back-to-back: a new request can be accepted in the cycle after the outReady handshake.
- reqReady is combinational from state only, with no dependence on reqValid.
- Reset asserted mid-fetch returns to IDLE immediately. A memory response arriving after reset deassertion is ignored.

## Test plan
- Reset then miss: reqBase=0x1000, reqU=5, reqV=9, reqPitch=4, reqFormat=5'h10. Required: memAddr sequence 0x1090, 0x1094, 0x1098, 0x109C. Responses 0x11111111..0x44444444 give outData=0x44444444_33333333_22222222_11111111, outXTexel=1, outYTexel=1.
- Repeat the same block with reqU=6, reqV=10: no memReqValid. outValid asserts the cycle after accept, with the same outData, outXTexel=2, outYTexel=2.
- 8-byte format 5'h00, reqBase=0x2000, reqU=4, reqV=0: exactly 2 beats at 0x2008 and 0x200C. outData[127:64]=0.
- Backpressure: hold memReqReady=0 for 5 cycles, then hold outReady=0 for 3 cycles. memAddr and outData must stay stable, and reqReady must stay 0 throughout.
- Flush during the first test's fetch (pulse in RESP): data is still delivered. Re-requesting the same block fetches from memory again.
- Reset mid-fetch after beat 1: all outputs return to reset values asynchronously. A subsequent identical request misses and issues 4 beats.
